// File: rtl/sound_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sound_arbiter
//  Purpose  : Shares the single speaker pin between three one-shot sound
//             players (jump, score milestone, game over). Fires one player
//             at a time by fixed priority, times each sound with its own
//             duration, adds a silent gap between sounds and gates the
//             selected player's square wave onto the speaker.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             req_jump/point/die - one-cycle request pulses (die highest)
//             mute               - level; aborts sound, blocks requests
//             wave_jump/point/die- square waves from the players
//             trig_jump/point/die- registered one-cycle player triggers
//             wave_out           - registered speaker output
//             busy               - high while playing or in the gap
//             active_id          - 0 none, 1 jump, 2 point, 3 die
//  Revision : 1.0 - initial release
// ============================================================================
module sound_arbiter #(
    parameter int unsigned TW         = 24,
    parameter int unsigned DUR_JUMP   = 10000020,
    parameter int unsigned DUR_POINT  = 4000000,
    parameter int unsigned DUR_DIE    = 15000000,
    parameter int unsigned GAP_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_jump,
    input  logic       req_point,
    input  logic       req_die,
    input  logic       mute,
    input  logic       wave_jump,
    input  logic       wave_point,
    input  logic       wave_die,
    output logic       trig_jump,
    output logic       trig_point,
    output logic       trig_die,
    output logic       wave_out,
    output logic       busy,
    output logic [1:0] active_id
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // Timers count down to zero, so each phase loads its length minus one.
    localparam logic [TW-1:0] c_load_jump  = TW'(DUR_JUMP - 1);
    localparam logic [TW-1:0] c_load_point = TW'(DUR_POINT - 1);
    localparam logic [TW-1:0] c_load_die   = TW'(DUR_DIE - 1);
    localparam logic [TW-1:0] c_load_gap   = TW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [TW-1:0] c_one        = TW'(1);

    logic [1:0]    r_state, w_state_nx;
    logic [1:0]    r_sel, w_sel_nx;
    logic [TW-1:0] r_timer, w_timer_nx;
    logic [2:0]    r_pend, w_pend_nx;
    logic [2:0]    r_trig, w_trig_nx;
    logic          r_wave_out, w_wave_nx;

    logic [2:0]    w_req;
    logic [1:0]    w_req_id;
    logic [1:0]    w_comb_id;
    logic          w_grant;
    logic [1:0]    w_grant_id;
    logic          w_sel_wave;

    // Highest set bit of {die, point, jump} as a source ID (0 = none).
    function automatic logic [1:0] f_top(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [TW-1:0] f_load(input logic [1:0] id);
        case (id)
            2'd1:    return c_load_jump;
            2'd2:    return c_load_point;
            2'd3:    return c_load_die;
            default: return '0;
        endcase
    endfunction

    function automatic logic [2:0] f_onehot(input logic [1:0] id);
        case (id)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign w_req     = {req_die, req_point, req_jump};
    assign w_req_id  = f_top(w_req);
    assign w_comb_id = f_top(r_pend | w_req);

    always_comb begin
        case (r_sel)
            2'd1:    w_sel_wave = wave_jump;
            2'd2:    w_sel_wave = wave_point;
            2'd3:    w_sel_wave = wave_die;
            default: w_sel_wave = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_timer_nx = r_timer;
        w_pend_nx  = r_pend;
        w_trig_nx  = 3'b000;
        w_grant    = 1'b0;
        w_grant_id = 2'd0;
        // The speaker follows the player only while it is actually playing;
        // mute silences it starting with the very next cycle.
        w_wave_nx  = (!mute && (r_state == S_PLAY)) ? w_sel_wave : 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req_id != 2'd0) begin
                    w_grant    = 1'b1;
                    w_grant_id = w_req_id;
                end else begin
                    w_sel_nx = 2'd0;
                end
            end
            S_PLAY: begin
                // Equal ID restarts the sound, higher ID preempts it; lower
                // requests are dropped and expiry proceeds as normal.
                if ((w_req_id != 2'd0) && (w_req_id >= r_sel)) begin
                    w_grant    = 1'b1;
                    w_grant_id = w_req_id;
                end else if (r_timer == '0) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nx = S_IDLE;
                        w_sel_nx   = 2'd0;
                    end else begin
                        w_state_nx = S_GAP;
                        w_timer_nx = c_load_gap;
                    end
                end else begin
                    w_timer_nx = r_timer - c_one;
                end
            end
            S_GAP: begin
                if (r_timer == '0) begin
                    w_pend_nx = 3'b000;
                    if (w_comb_id != 2'd0) begin
                        w_grant    = 1'b1;
                        w_grant_id = w_comb_id;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_sel_nx   = 2'd0;
                    end
                end else begin
                    w_pend_nx  = r_pend | w_req;
                    w_timer_nx = r_timer - c_one;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_sel_nx   = 2'd0;
                w_pend_nx  = 3'b000;
            end
        endcase

        if (w_grant) begin
            w_state_nx = S_PLAY;
            w_sel_nx   = w_grant_id;
            w_timer_nx = f_load(w_grant_id);
            w_trig_nx  = f_onehot(w_grant_id);
        end

        if (mute) begin
            w_state_nx = S_IDLE;
            w_sel_nx   = 2'd0;
            w_timer_nx = '0;
            w_pend_nx  = 3'b000;
            w_trig_nx  = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'd0;
            r_timer    <= '0;
            r_pend     <= 3'b000;
            r_trig     <= 3'b000;
            r_wave_out <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sel      <= w_sel_nx;
            r_timer    <= w_timer_nx;
            r_pend     <= w_pend_nx;
            r_trig     <= w_trig_nx;
            r_wave_out <= w_wave_nx;
        end
    end

    assign trig_jump  = r_trig[0];
    assign trig_point = r_trig[1];
    assign trig_die   = r_trig[2];
    assign wave_out   = r_wave_out;
    assign busy       = (r_state != S_IDLE);
    assign active_id  = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_sound_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sound_arbiter
//  Purpose  : Self-checking bench for sound_arbiter: a fixed vector table,
//             hand-written corner sequences and randomized traffic compared
//             against a phase/remaining-cycles reference model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sound_arbiter;

    localparam int c_dur_jump  = 20;
    localparam int c_dur_point = 12;
    localparam int c_dur_die   = 30;
    localparam int c_gap       = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_jump = 1'b0, req_point = 1'b0, req_die = 1'b0;
    logic       mute = 1'b0;
    logic       wave_jump = 1'b0, wave_point = 1'b0, wave_die = 1'b0;
    logic       trig_jump, trig_point, trig_die;
    logic       wave_out, busy;
    logic [1:0] active_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sound_arbiter #(
        .TW(24), .DUR_JUMP(c_dur_jump), .DUR_POINT(c_dur_point),
        .DUR_DIE(c_dur_die), .GAP_CYCLES(c_gap)
    ) dut (
        .clk(clk), .rst(rst),
        .req_jump(req_jump), .req_point(req_point), .req_die(req_die),
        .mute(mute),
        .wave_jump(wave_jump), .wave_point(wave_point), .wave_die(wave_die),
        .trig_jump(trig_jump), .trig_point(trig_point), .trig_die(trig_die),
        .wave_out(wave_out), .busy(busy), .active_id(active_id)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Phase plus number of cycles still left in it (including the current one).
    localparam int P_IDLE = 0, P_PLAY = 1, P_GAP = 2;
    int         m_phase = P_IDLE;
    int         m_sel   = 0;
    int         m_rem   = 0;
    logic [2:0] m_pend  = 3'b000;
    logic [2:0] m_trig  = 3'b000;
    logic       m_wave  = 1'b0;

    function automatic int top_of(input logic [2:0] v);
        if (v[2]) return 3;
        if (v[1]) return 2;
        if (v[0]) return 1;
        return 0;
    endfunction

    function automatic int dur_of(input int id);
        if (id == 1) return c_dur_jump;
        if (id == 2) return c_dur_point;
        return c_dur_die;
    endfunction

    task automatic model_grant(input int id);
        m_phase = P_PLAY;
        m_sel   = id;
        m_rem   = dur_of(id);
        m_trig  = 3'b001 << (id - 1);
    endtask

    task automatic model_step();
        logic [2:0] r;
        logic [3:0] wv;
        int top;
        r  = {req_die, req_point, req_jump};
        wv = {wave_die, wave_point, wave_jump, 1'b0};
        if (rst) begin
            m_phase = P_IDLE; m_sel = 0; m_rem = 0; m_pend = 0;
            m_trig = 0; m_wave = 0;
            return;
        end
        m_wave = (!mute && m_phase == P_PLAY) ? wv[m_sel] : 1'b0;
        m_trig = 3'b000;
        if (mute) begin
            m_phase = P_IDLE; m_sel = 0; m_pend = 0; m_rem = 0;
            return;
        end
        if (m_phase == P_IDLE) begin
            top = top_of(r);
            if (top != 0) model_grant(top);
        end else if (m_phase == P_PLAY) begin
            top = top_of(r);
            if (top != 0 && top >= m_sel) model_grant(top);
            else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    if (c_gap > 0) begin m_phase = P_GAP; m_rem = c_gap; end
                    else begin m_phase = P_IDLE; m_sel = 0; end
                end
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                top    = top_of(m_pend | r);
                m_pend = 3'b000;
                if (top != 0) model_grant(top);
                else begin m_phase = P_IDLE; m_sel = 0; end
            end else begin
                m_pend = m_pend | r;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle(input logic a_rst, input logic a_mute, input logic [2:0] a_req);
        @(negedge clk);
        rst = a_rst; mute = a_mute;
        {req_die, req_point, req_jump} = a_req;
        wave_jump  = cyc[0];
        wave_point = cyc[1];
        wave_die   = (cyc % 3 == 0);
        cyc++;
        @(posedge clk);
        model_step();
        #1;
        chk("model_trig", 32'({trig_die, trig_point, trig_jump}), 32'(m_trig));
        chk("model_busy", 32'(busy), 32'(m_phase != P_IDLE));
        chk("model_id", 32'(active_id), 32'(m_sel));
        chk("model_wave", 32'(wave_out), 32'(m_wave));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'b000);
    endtask

    // Counts further busy cycles until the block goes idle (bounded).
    task automatic run_busy(input int start, output int n);
        n = start;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b0, 3'b000);
            if (busy) n++;
            else break;
        end
    endtask

    typedef struct {
        logic       rst;
        logic       mute;
        logic [2:0] req;
        logic [2:0] e_trig;
        logic       e_busy;
        logic [1:0] e_id;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        logic [2:0] rq;
        logic       rm, rr;

        // {rst, mute, {die,point,jump}} -> {trig, busy, active_id} after the edge
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 1'b0, 3'b111, 3'b100, 1'b1, 2'd3};
        tbl[3]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 2'd3};
        tbl[4]  = '{1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 2'd3};
        tbl[5]  = '{1'b0, 1'b0, 3'b100, 3'b100, 1'b1, 2'd3};
        tbl[6]  = '{1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 2'd2};
        tbl[9]  = '{1'b0, 1'b0, 3'b011, 3'b010, 1'b1, 2'd2};
        tbl[10] = '{1'b0, 1'b0, 3'b100, 3'b100, 1'b1, 2'd3};
        tbl[11] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0};

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst, tbl[i].mute, tbl[i].req);
            chk("tbl_trig", 32'({trig_die, trig_point, trig_jump}), 32'(tbl[i].e_trig));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
            chk("tbl_id", 32'(active_id), 32'(tbl[i].e_id));
        end

        // 1: single jump after reset
        cycle(1'b1, 1'b0, 3'b000);
        chk("reset_wave", 32'(wave_out), 32'd0);
        idle(9);
        cycle(1'b0, 1'b0, 3'b001);
        chk("t1_trig", 32'({trig_die, trig_point, trig_jump}), 32'b001);
        chk("t1_id", 32'(active_id), 32'd1);
        cycle(1'b0, 1'b0, 3'b000);
        chk("t1_trig_once", 32'(trig_jump), 32'd0);
        run_busy(2, n);
        chk("t1_busy_len", 32'(n), 32'(c_dur_jump + c_gap));

        // 2: simultaneous requests from idle
        cycle(1'b0, 1'b0, 3'b111);
        chk("t2_trig", 32'({trig_die, trig_point, trig_jump}), 32'b100);
        chk("t2_id", 32'(active_id), 32'd3);
        run_busy(1, n);
        chk("t2_busy_len", 32'(n), 32'(c_dur_die + c_gap));

        // 3: preempt by point at play cycle 5, then a discarded jump
        cycle(1'b0, 1'b0, 3'b001);
        idle(4);
        cycle(1'b0, 1'b0, 3'b010);
        chk("t3_trig", 32'({trig_die, trig_point, trig_jump}), 32'b010);
        chk("t3_id", 32'(active_id), 32'd2);
        n = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 3'b000);
            if (busy) n++;
        end
        cycle(1'b0, 1'b0, 3'b001);
        chk("t3_discard", 32'({trig_die, trig_point, trig_jump}), 32'b000);
        chk("t3_keep_id", 32'(active_id), 32'd2);
        if (busy) n++;
        run_busy(n, n);
        chk("t3_busy_len", 32'(n), 32'(c_dur_point + c_gap));

        // 4: restart jump at play cycle 15
        cycle(1'b0, 1'b0, 3'b001);
        idle(14);
        cycle(1'b0, 1'b0, 3'b001);
        chk("t4_retrig", 32'({trig_die, trig_point, trig_jump}), 32'b001);
        run_busy(1, n);
        chk("t4_busy_len", 32'(n), 32'(c_dur_jump + c_gap));

        // 5: request in gap cycle 1 waits for the gap to expire
        cycle(1'b0, 1'b0, 3'b001);
        idle(c_dur_jump);
        cycle(1'b0, 1'b0, 3'b001);
        chk("t5_no_trig_req", 32'({trig_die, trig_point, trig_jump}), 32'b000);
        idle(2);
        chk("t5_no_trig_gap", 32'({trig_die, trig_point, trig_jump}), 32'b000);
        chk("t5_gap_wave", 32'(wave_out), 32'd0);
        chk("t5_gap_busy", 32'(busy), 32'd1);
        idle(1);
        chk("t5_pend_trig", 32'({trig_die, trig_point, trig_jump}), 32'b001);
        run_busy(1, n);
        chk("t5_busy_len", 32'(n), 32'(c_dur_jump + c_gap));
        idle(3);
        chk("t5_pend_cleared", 32'(busy), 32'd0);

        // 6: mute and reset mid-sound
        cycle(1'b0, 1'b0, 3'b001);
        idle(5);
        cycle(1'b0, 1'b1, 3'b100);
        chk("t6_mute_wave", 32'(wave_out), 32'd0);
        chk("t6_mute_busy", 32'(busy), 32'd0);
        chk("t6_mute_trig", 32'({trig_die, trig_point, trig_jump}), 32'b000);
        cycle(1'b0, 1'b1, 3'b011);
        chk("t6_mute_block", 32'({trig_die, trig_point, trig_jump}), 32'b000);
        cycle(1'b0, 1'b0, 3'b010);
        idle(3);
        cycle(1'b1, 1'b0, 3'b000);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_id", 32'(active_id), 32'd0);
        chk("t6_rst_wave", 32'(wave_out), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rq = 3'b000;
            for (int b = 0; b < 3; b++) rq[b] = ($urandom_range(0, 15) == 0);
            rm = ($urandom_range(0, 63) == 0);
            rr = ($urandom_range(0, 299) == 0);
            cycle(rr, rm, rq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sound_arbiter.md
# sound_arbiter

Schedules the game's sound effects onto the single speaker pin. Three requesters share the one output: jump, score milestone and game over. Each requester drives its own one-shot sound player. This block fires exactly one player at a time by fixed priority, times each sound with its own duration counter, and inserts a silent gap between sounds. It also gates the selected player's square wave onto the speaker, because the players idle with their outputs high.

## Interface
Parameters:
- TW, 24, width of the duration/gap timers
- DUR_JUMP, 10000020, jump sound length in clk cycles (30 stages × 333334)
- DUR_POINT, 4000000, score sound length in cycles
- DUR_DIE, 15000000, game-over sound length in cycles
- GAP_CYCLES, 250000, silent cycles after a sound ends (0 = no gap)
- Constraint: every DUR_* must be ≥1 and ≤2^TW; GAP_CYCLES must be ≤2^TW.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, synchronous, active-high
- req_jump  in  1  one-cycle request pulse, priority 0 (lowest)
- req_point  in  1  one-cycle request pulse, priority 1
- req_die  in  1  one-cycle request pulse, priority 2 (highest)
- mute  in  1  level; 1 aborts the current sound and blocks all requests
- wave_jump, wave_point, wave_die  in  1 each  square waves from the players
- trig_jump, trig_point, trig_die  out  1 each  one-cycle trigger to the matching player
- wave_out  out  1  registered speaker output
- busy  out  1  high in PLAY and GAP
- active_id  out  2  0 = none, 1 = jump, 2 = point, 3 = die

## Operation
- States: IDLE, PLAY, GAP. A register `sel` (2 bits) holds the current source ID. A TW-bit down-counter `timer` times PLAY and GAP. `pend` (3 bits) latches requests that arrive during GAP.
- Grant: pick the highest-priority asserted request. At that edge:
  - pulse the matching trig_* for the next cycle;
  - set sel to the source;
  - load timer with DUR_x−1;
  - go to PLAY.
- IDLE:
  - any request → grant.
  - otherwise stay in IDLE, with sel=0.
- PLAY:
  - Request with higher priority than sel → preempt: grant the new source and restart timing.
  - Request from the same source → restart: re-trigger and reload timer.
  - Request with lower priority → discarded.
  - Request handling takes precedence over expiry at the same edge.
  - With no request: timer==0 → go to GAP with timer=GAP_CYCLES−1, or go to IDLE with sel=0 when GAP_CYCLES=0. Otherwise timer decrements.
- GAP:
  - Requests are ORed into pend.
  - When timer==0: take the combined set (pend | current requests). If it is non-empty, grant the highest source in it and clear pend; otherwise go to IDLE with sel=0.
  - Otherwise timer decrements.
  - Lower-priority entries in pend are discarded at the grant.
- Multiple requests in the same cycle: the highest priority wins; the others are dropped, except in GAP, where they remain latched until the gap ends.
- mute=1 at an edge:
  - state goes to IDLE; pend, sel and trig_* are cleared;
  - mute overrides every request and every transition.
- Outputs:
  - wave_out ← (state==PLAY) ? wave of sel : 0.
  - active_id = sel.
  - busy = (state≠IDLE).
  - trig_* are registered; at most one is high in any cycle.

## Timing
- Reset: state=IDLE, sel=0, pend=0, timer=0, trig_*=0, wave_out=0, busy=0, active_id=0.
- Request sampled at edge k:
  - the trig is high in cycle k+1 only;
  - busy and active_id update in cycle k+1;
  - wave_out follows the player wave from edge k+2, one register of latency.
- PLAY lasts exactly DUR_x cycles, then GAP lasts exactly GAP_CYCLES cycles. wave_out is 0 through the whole gap.
- Preempt or restart: the new trig pulse is high in the cycle after the request. There is no gap cycle between the aborted and the new sound.
- Reset or mute mid-sound: wave_out is 0 from the next cycle. No trig is issued.

## Test plan
Bench parameters: DUR_JUMP=20, DUR_POINT=12, DUR_DIE=30, GAP_CYCLES=4, with toggling player waves.
1. Reset, then req_jump at edge 10 → trig_jump high in cycle 11 only; active_id=1; busy high for 24 cycles; wave_out tracks wave_jump for 20 cycles, then is 0.
2. req_jump, req_point and req_die in the same cycle from IDLE → only trig_die fires; active_id=3; PLAY lasts 30 cycles.
3. Preempt and discard:
   - req_point at cycle 5 of a jump → trig_point fires, active_id=2, PLAY lasts 12 cycles from the preempt;
   - req_jump during the point sound → ignored, no trig.
4. Restart: req_jump at cycle 15 of a jump → second trig_jump fires; PLAY ends 20 cycles after the re-trigger.
5. req_jump during GAP cycle 1 → no trig until the gap expires; trig_jump fires in the cycle after the last gap cycle; pend is cleared.
6. Abort:
   - mute=1 mid-sound → wave_out=0 and busy=0 next cycle; requests produce no trig while mute=1;
   - rst mid-sound → all reset values next cycle.
